// File: rtl/time_set_controller.sv
// Time-set sequencer: chains tick/overflow pulses into counter enables in run mode,
// and turns hour/minute buttons into increment strobes with press-and-hold auto-repeat.
module time_set_controller #(
   parameter int REPEAT_DELAY = 5,
   parameter int DLY_WIDTH    = 8
) (
   input  logic       i_sysclk,
   input  logic       i_reset,
   input  logic       i_tick_1hz,
   input  logic       i_fast_tick,
   input  logic       i_btn_hr,
   input  logic       i_btn_min,
   input  logic       i_sec_ovf,
   input  logic       i_min_ovf,
   output logic       o_sec_en,
   output logic       o_min_en,
   output logic       o_hr_en,
   output logic       o_sec_clear,
   output logic [1:0] o_state
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   localparam logic [DLY_WIDTH-1:0] DLY_ONE   = {{(DLY_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DLY_WIDTH-1:0] DLY_LIMIT = DLY_WIDTH'(REPEAT_DELAY);

   state_t                state_q, state_d;
   logic                  tgt_hr_q, tgt_hr_d;
   logic [DLY_WIDTH-1:0]  hold_cnt_q, hold_cnt_d;
   logic                  btn_hr_prev_q, btn_hr_prev_d;
   logic                  btn_min_prev_q, btn_min_prev_d;
   logic                  sec_en_q, sec_en_d;
   logic                  min_en_q, min_en_d;
   logic                  hr_en_q, hr_en_d;
   logic                  sec_clear_q, sec_clear_d;

   logic                  hr_rise;
   logic                  min_rise;
   logic                  tgt_btn;
   logic [DLY_WIDTH-1:0]  hold_cnt_inc;

   assign hr_rise      = i_btn_hr & ~btn_hr_prev_q;
   assign min_rise     = i_btn_min & ~btn_min_prev_q;
   assign tgt_btn      = tgt_hr_q ? i_btn_hr : i_btn_min;
   assign hold_cnt_inc = hold_cnt_q + DLY_ONE;

   always_comb begin
      state_d        = state_q;
      tgt_hr_d       = tgt_hr_q;
      hold_cnt_d     = hold_cnt_q;
      btn_hr_prev_d  = i_btn_hr;
      btn_min_prev_d = i_btn_min;
      sec_en_d       = 1'b0;
      min_en_d       = 1'b0;
      hr_en_d        = 1'b0;

      case (state_q)
         ST_RUN: begin
            sec_en_d = i_tick_1hz;
            min_en_d = i_sec_ovf;
            hr_en_d  = i_min_ovf;
            // A press takes over this cycle's enables; hours wins a tie.
            if (hr_rise) begin
               state_d    = ST_HOLD;
               tgt_hr_d   = 1'b1;
               hold_cnt_d = '0;
               sec_en_d   = 1'b0;
               min_en_d   = 1'b0;
               hr_en_d    = 1'b1;
            end else if (min_rise) begin
               state_d    = ST_HOLD;
               tgt_hr_d   = 1'b0;
               hold_cnt_d = '0;
               sec_en_d   = 1'b0;
               min_en_d   = 1'b1;
               hr_en_d    = 1'b0;
            end
         end
         ST_HOLD, ST_REPEAT: begin
            // Release takes priority over a coincident fast tick.
            if (!tgt_btn) begin
               state_d    = ST_RUN;
               hold_cnt_d = '0;
            end else if (i_fast_tick) begin
               if (state_q == ST_REPEAT) begin
                  hr_en_d  = tgt_hr_q;
                  min_en_d = ~tgt_hr_q;
               end else begin
                  hold_cnt_d = hold_cnt_inc;
                  if (hold_cnt_inc == DLY_LIMIT) begin
                     state_d  = ST_REPEAT;
                     hr_en_d  = tgt_hr_q;
                     min_en_d = ~tgt_hr_q;
                  end
               end
            end
         end
         default: begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
         end
      endcase

      sec_clear_d = (state_d != ST_RUN);
   end

   always_ff @(posedge i_sysclk or posedge i_reset) begin
      if (i_reset) begin
         state_q        <= ST_RUN;
         tgt_hr_q       <= 1'b0;
         hold_cnt_q     <= '0;
         btn_hr_prev_q  <= 1'b1;
         btn_min_prev_q <= 1'b1;
         sec_en_q       <= 1'b0;
         min_en_q       <= 1'b0;
         hr_en_q        <= 1'b0;
         sec_clear_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         tgt_hr_q       <= tgt_hr_d;
         hold_cnt_q     <= hold_cnt_d;
         btn_hr_prev_q  <= btn_hr_prev_d;
         btn_min_prev_q <= btn_min_prev_d;
         sec_en_q       <= sec_en_d;
         min_en_q       <= min_en_d;
         hr_en_q        <= hr_en_d;
         sec_clear_q    <= sec_clear_d;
      end
   end

   assign o_sec_en    = sec_en_q;
   assign o_min_en    = min_en_q;
   assign o_hr_en     = hr_en_q;
   assign o_sec_clear = sec_clear_q;
   assign o_state     = state_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with REPEAT_DELAY = 3; outputs are
// sampled 1 time unit after each rising edge, inputs driven at the same point.
module tb_time_set_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_1hz = 1'b0;
   logic       fast_tick = 1'b0;
   logic       btn_hr = 1'b0;
   logic       btn_min = 1'b0;
   logic       sec_ovf = 1'b0;
   logic       min_ovf = 1'b0;
   logic       sec_en;
   logic       min_en;
   logic       hr_en;
   logic       sec_clear;
   logic [1:0] state;

   int tests_run = 0;
   int tests_failed = 0;

   time_set_controller #(.REPEAT_DELAY(3), .DLY_WIDTH(8)) dut (
      .i_sysclk    (clk),
      .i_reset     (rst),
      .i_tick_1hz  (tick_1hz),
      .i_fast_tick (fast_tick),
      .i_btn_hr    (btn_hr),
      .i_btn_min   (btn_min),
      .i_sec_ovf   (sec_ovf),
      .i_min_ovf   (min_ovf),
      .o_sec_en    (sec_en),
      .o_min_en    (min_en),
      .o_hr_en     (hr_en),
      .o_sec_clear (sec_clear),
      .o_state     (state)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed {sec_en,min_en,hr_en,sec_clear,state}=%b required=%b", tag, obs, exp);
      end
   endtask

   // Packs all outputs: {sec_en, min_en, hr_en, sec_clear, state[1:0]}
   function automatic logic [5:0] outs();
      return {sec_en, min_en, hr_en, sec_clear, state};
   endfunction

   initial begin
      // Reset
      #3;
      check("reset_async", outs(), 6'b000000);
      step();
      step();
      rst = 1'b0;
      step();
      check("reset_release", outs(), 6'b000000);

      // Run chaining
      tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
      check("run_tick_to_sec_en", outs(), 6'b100000);
      step();
      check("run_sec_en_one_wide", outs(), 6'b000000);
      sec_ovf = 1'b1; step(); sec_ovf = 1'b0;
      check("run_secovf_to_min_en", outs(), 6'b010000);
      step();
      check("run_min_en_one_wide", outs(), 6'b000000);
      min_ovf = 1'b1; step(); min_ovf = 1'b0;
      check("run_minovf_to_hr_en", outs(), 6'b001000);
      step();
      check("run_hr_en_one_wide", outs(), 6'b000000);

      // Single hour press, no fast ticks
      btn_hr = 1'b1; step();
      check("hr_press_strobe", outs(), 6'b001101);
      for (int i = 0; i < 5; i++) begin
         step();
         check("hr_hold_quiet", outs(), 6'b000101);
      end
      btn_hr = 1'b0; step();
      check("hr_release_run", outs(), 6'b000000);

      // Minute press with fast tick on the press cycle (not counted)
      btn_min = 1'b1; fast_tick = 1'b1; step(); fast_tick = 1'b0;
      check("min_press_strobe", outs(), 6'b010101);
      step();
      check("min_hold_quiet", outs(), 6'b000101);
      for (int n = 1; n <= 5; n++) begin
         fast_tick = 1'b1; step(); fast_tick = 1'b0;
         if (n < 3) check("min_fast_tick_hold", outs(), 6'b000101);
         else       check("min_fast_tick_repeat", outs(), 6'b010110);
         step();
         if (n < 3) check("min_between_ticks_hold", outs(), 6'b000101);
         else       check("min_between_ticks_repeat", outs(), 6'b000110);
      end

      // Carry suppression and non-target button ignored
      min_ovf = 1'b1; tick_1hz = 1'b1; sec_ovf = 1'b1; btn_hr = 1'b1; step();
      min_ovf = 1'b0; tick_1hz = 1'b0; sec_ovf = 1'b0;
      check("set_carry_suppressed", outs(), 6'b000110);
      btn_hr = 1'b0; step();
      check("set_nontarget_release", outs(), 6'b000110);

      // Release coincident with fast tick: no strobe, back to RUN
      btn_min = 1'b0; fast_tick = 1'b1; step(); fast_tick = 1'b0;
      check("release_beats_fast_tick", outs(), 6'b000000);
      min_ovf = 1'b1; step(); min_ovf = 1'b0;
      check("run_carry_after_release", outs(), 6'b001000);

      // Re-press: immediate strobe and a fresh delay
      btn_min = 1'b1; step();
      check("repress_strobe", outs(), 6'b010101);
      fast_tick = 1'b1; step(); fast_tick = 1'b0;
      check("repress_fresh_delay", outs(), 6'b000101);
      btn_min = 1'b0; step();
      check("repress_release", outs(), 6'b000000);

      // Simultaneous presses: hours wins
      btn_hr = 1'b1; btn_min = 1'b1; step();
      check("both_press_hours", outs(), 6'b001101);
      btn_min = 1'b0; step();
      check("both_min_release_ignored", outs(), 6'b000101);
      for (int n = 1; n <= 3; n++) begin
         fast_tick = 1'b1; step(); fast_tick = 1'b0;
         check("hr_repeat_ticks", outs(), (n < 3) ? 6'b000101 : 6'b001110);
      end
      btn_hr = 1'b0; step();
      check("both_hr_release", outs(), 6'b000000);

      // Reset mid-REPEAT with button still held
      btn_min = 1'b1; step();
      for (int n = 1; n <= 3; n++) begin
         fast_tick = 1'b1; step(); fast_tick = 1'b0;
      end
      check("pre_reset_repeat_strobe", outs(), 6'b010110);
      #2 rst = 1'b1;
      #1;
      check("reset_mid_repeat_async", outs(), 6'b000000);
      step();
      rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
         fast_tick = 1'b1; step(); fast_tick = 1'b0;
         check("held_through_reset_ignored", outs(), 6'b000000);
      end
      btn_min = 1'b0; step();
      check("post_reset_release", outs(), 6'b000000);
      btn_min = 1'b1; step();
      check("post_reset_new_press", outs(), 6'b010101);
      btn_min = 1'b0; step();
      check("post_reset_final_release", outs(), 6'b000000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
